// File: rtl/ft245_fifo_bridge.sv
// FT245-style parallel FIFO pad bridge: RX/TX FIFOs on the user side, a
// round-robin read/write strobe sequencer on the pad side.
module ft245_fifo_bridge #(
    parameter int unsigned RX_DEPTH = 16,
    parameter int unsigned TX_DEPTH = 16,
    parameter int unsigned RD_PULSE = 4,
    parameter int unsigned WR_SETUP = 2,
    parameter int unsigned WR_PULSE = 4,
    parameter int unsigned GAP      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          uart_txe,
    input  logic                          uart_rxf,
    input  logic [7:0]                    uart_di,
    output logic [7:0]                    uart_do,
    output logic                          uart_oe,
    output logic                          uart_wr,
    output logic                          uart_rd,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic [$clog2(RX_DEPTH):0]     rx_count,
    output logic [$clog2(TX_DEPTH):0]     tx_count
);

    localparam int unsigned RAW = $clog2(RX_DEPTH);
    localparam int unsigned TAW = $clog2(TX_DEPTH);
    localparam int unsigned M1  = (RD_PULSE > WR_SETUP) ? RD_PULSE : WR_SETUP;
    localparam int unsigned M2  = (M1 > WR_PULSE) ? M1 : WR_PULSE;
    localparam int unsigned M3  = (M2 > GAP) ? M2 : GAP;
    localparam int unsigned CW  = $clog2(M3) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR_SU,
        S_WR,
        S_GAP
    } state_t;

    logic          stxe_meta_q, stxe_q, srxf_meta_q, srxf_q;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_wr_q, last_wr_d;
    logic [7:0]    uart_do_q, uart_do_d;
    logic          uart_rd_q, uart_rd_d;
    logic          uart_wr_q, uart_wr_d;
    logic          uart_oe_q, uart_oe_d;

    logic [7:0]    rx_mem_q [RX_DEPTH];
    logic [7:0]    rx_mem_d [RX_DEPTH];
    logic [RAW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [RAW:0]  rx_cnt_q, rx_cnt_d;

    logic [7:0]    tx_mem_q [TX_DEPTH];
    logic [7:0]    tx_mem_d [TX_DEPTH];
    logic [TAW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [TAW:0]  tx_cnt_q, tx_cnt_d;

    logic rx_full, tx_full, rx_push, rx_pop, tx_push, tx_pop;
    logic rreq, wreq, cnt_last;

    assign rx_full  = (rx_cnt_q == (RAW+1)'(RX_DEPTH));
    assign tx_full  = (tx_cnt_q == (TAW+1)'(TX_DEPTH));
    assign rx_valid = (rx_cnt_q != '0);
    assign rx_data  = rx_mem_q[rx_rptr_q];
    assign tx_ready = !tx_full;
    assign rx_count = rx_cnt_q;
    assign tx_count = tx_cnt_q;
    assign uart_do  = uart_do_q;
    assign uart_rd  = uart_rd_q;
    assign uart_wr  = uart_wr_q;
    assign uart_oe  = uart_oe_q;

    assign rreq     = !srxf_q && !rx_full;
    assign wreq     = !stxe_q && (tx_cnt_q != '0);
    assign cnt_last = (cnt_q == '0);
    assign rx_pop   = rx_valid && rx_ready;
    assign tx_push  = tx_valid && tx_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_wr_d = last_wr_q;
        uart_do_d = uart_do_q;
        rx_push   = 1'b0;
        tx_pop    = 1'b0;
        case (state_q)
            S_IDLE: begin
                // last_wr_q set means RD has priority on contention
                if (rreq && (!wreq || last_wr_q)) begin
                    state_d   = S_RD;
                    cnt_d     = CW'(RD_PULSE - 1);
                    last_wr_d = 1'b0;
                end else if (wreq) begin
                    state_d   = S_WR_SU;
                    cnt_d     = CW'(WR_SETUP - 1);
                    last_wr_d = 1'b1;
                    uart_do_d = tx_mem_q[tx_rptr_q];
                end
            end
            S_RD: begin
                if (cnt_last) begin
                    rx_push = !rx_full;
                    state_d = S_GAP;
                    cnt_d   = CW'(GAP - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_WR_SU: begin
                if (cnt_last) begin
                    state_d = S_WR;
                    cnt_d   = CW'(WR_PULSE - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_WR: begin
                if (cnt_last) begin
                    tx_pop  = 1'b1;
                    state_d = S_GAP;
                    cnt_d   = CW'(GAP - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_GAP: begin
                if (cnt_last) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        // Strobes are decoded from the next state so they line up with state_q.
        uart_rd_d = (state_d == S_RD);
        uart_wr_d = (state_d == S_WR);
        uart_oe_d = (state_d == S_WR_SU) || (state_d == S_WR);
    end

    always_comb begin
        rx_mem_d  = rx_mem_q;
        rx_wptr_d = rx_wptr_q;
        rx_rptr_d = rx_rptr_q;
        rx_cnt_d  = rx_cnt_q;
        if (rx_push) begin
            rx_mem_d[rx_wptr_q] = uart_di;
            rx_wptr_d = rx_wptr_q + RAW'(1);
        end
        if (rx_pop) begin
            rx_rptr_d = rx_rptr_q + RAW'(1);
        end
        case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + (RAW+1)'(1);
            2'b01:   rx_cnt_d = rx_cnt_q - (RAW+1)'(1);
            default: rx_cnt_d = rx_cnt_q;
        endcase
    end

    always_comb begin
        tx_mem_d  = tx_mem_q;
        tx_wptr_d = tx_wptr_q;
        tx_rptr_d = tx_rptr_q;
        tx_cnt_d  = tx_cnt_q;
        if (tx_push) begin
            tx_mem_d[tx_wptr_q] = tx_data;
            tx_wptr_d = tx_wptr_q + TAW'(1);
        end
        if (tx_pop) begin
            tx_rptr_d = tx_rptr_q + TAW'(1);
        end
        case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + (TAW+1)'(1);
            2'b01:   tx_cnt_d = tx_cnt_q - (TAW+1)'(1);
            default: tx_cnt_d = tx_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        rx_mem_q <= rx_mem_d;
        tx_mem_q <= tx_mem_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stxe_meta_q <= 1'b1;
            stxe_q      <= 1'b1;
            srxf_meta_q <= 1'b1;
            srxf_q      <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            last_wr_q   <= 1'b1;
            uart_do_q   <= '0;
            uart_rd_q   <= 1'b0;
            uart_wr_q   <= 1'b0;
            uart_oe_q   <= 1'b0;
            rx_wptr_q   <= '0;
            rx_rptr_q   <= '0;
            rx_cnt_q    <= '0;
            tx_wptr_q   <= '0;
            tx_rptr_q   <= '0;
            tx_cnt_q    <= '0;
        end else begin
            stxe_meta_q <= uart_txe;
            stxe_q      <= stxe_meta_q;
            srxf_meta_q <= uart_rxf;
            srxf_q      <= srxf_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_wr_q   <= last_wr_d;
            uart_do_q   <= uart_do_d;
            uart_rd_q   <= uart_rd_d;
            uart_wr_q   <= uart_wr_d;
            uart_oe_q   <= uart_oe_d;
            rx_wptr_q   <= rx_wptr_d;
            rx_rptr_q   <= rx_rptr_d;
            rx_cnt_q    <= rx_cnt_d;
            tx_wptr_q   <= tx_wptr_d;
            tx_rptr_q   <= tx_rptr_d;
            tx_cnt_q    <= tx_cnt_d;
        end
    end

endmodule

// File: tb/tb_ft245_fifo_bridge.sv
// Directed bench for ft245_fifo_bridge with a small FT245 pad model.
module tb_ft245_fifo_bridge;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_txe, uart_rxf;
    logic [7:0] uart_di, uart_do;
    logic       uart_oe, uart_wr, uart_rd;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [4:0] rx_count, tx_count;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic       rd_prev, oe_prev;
    logic [7:0] pad_base;
    int unsigned rd_starts;
    logic       seq[$];
    logic [7:0] wbytes[$];

    ft245_fifo_bridge #(
        .RX_DEPTH(16), .TX_DEPTH(16), .RD_PULSE(4),
        .WR_SETUP(2), .WR_PULSE(4), .GAP(4)
    ) dut (
        .clk(clk), .rst(rst),
        .uart_txe(uart_txe), .uart_rxf(uart_rxf),
        .uart_di(uart_di), .uart_do(uart_do),
        .uart_oe(uart_oe), .uart_wr(uart_wr), .uart_rd(uart_rd),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_count(rx_count), .tx_count(tx_count)
    );

    always #5 clk = ~clk;

    // One clock; the pad model presents the next byte when a read strobe starts
    // and logs transfer order (0 = read, 1 = write) plus bytes written.
    task automatic tick();
        @(posedge clk);
        #1;
        if (uart_rd && !rd_prev) begin
            uart_di = pad_base + 8'(rd_starts);
            rd_starts++;
            seq.push_back(1'b0);
        end
        if (uart_oe && !oe_prev) begin
            seq.push_back(1'b1);
            wbytes.push_back(uart_do);
        end
        rd_prev = uart_rd;
        oe_prev = uart_oe;
    endtask

    task automatic apply_reset();
        rst = 1'b0; uart_txe = 1'b1; uart_rxf = 1'b1; uart_di = 8'h00;
        rx_ready = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        repeat (3) tick();
        rst = 1'b1;
        seq.delete(); wbytes.delete(); rd_starts = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({uart_rd, uart_wr, uart_oe, rx_valid, tx_ready} !== 5'b00001) begin
            n_fail++;
            $display("FAIL reset_flags: got rd/wr/oe/rxv/txr=%b expected 00001",
                     {uart_rd, uart_wr, uart_oe, rx_valid, tx_ready});
        end
        n_checks++;
        if ({rx_count, tx_count, uart_do} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_counts: got rxc=%0d txc=%0d do=%h expected 0 0 00",
                     rx_count, tx_count, uart_do);
        end
    endtask

    task automatic test_single_read();
        apply_reset();
        pad_base = 8'hA5;
        uart_rxf = 1'b0;
        for (int unsigned k = 1; k <= 6; k++) begin
            tick();
            if (k == 4) uart_rxf = 1'b1;
            n_checks++;
            if (uart_rd !== (k >= 3)) begin
                n_fail++;
                $display("FAIL read_strobe_k%0d: got %b expected %b", k, uart_rd, (k >= 3));
            end
        end
        tick();
        n_checks++;
        if ({uart_rd, rx_valid, rx_data, rx_count} !== {1'b0, 1'b1, 8'hA5, 5'd1}) begin
            n_fail++;
            $display("FAIL read_result: got rd=%b rxv=%b data=%h cnt=%0d expected 0 1 a5 1",
                     uart_rd, rx_valid, rx_data, rx_count);
        end
        for (int unsigned k = 0; k < 10; k++) begin
            tick();
            n_checks++;
            if ({uart_rd, uart_wr, uart_oe} !== 3'b000) begin
                n_fail++;
                $display("FAIL read_gap_%0d: got rd/wr/oe=%b expected 000", k, {uart_rd, uart_wr, uart_oe});
            end
        end
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        n_checks++;
        if ({rx_valid, rx_count} !== 6'd0) begin
            n_fail++;
            $display("FAIL read_pop: got rxv=%b cnt=%0d expected 0 0", rx_valid, rx_count);
        end
    endtask

    task automatic test_single_write();
        apply_reset();
        tx_valid = 1'b1; tx_data = 8'h3C;
        tick();
        tx_valid = 1'b0;
        uart_txe = 1'b0;
        for (int unsigned k = 1; k <= 8; k++) begin
            tick();
            if (k == 4) uart_txe = 1'b1;
            n_checks++;
            if ({uart_oe, uart_wr, uart_rd, tx_count} !== {(k >= 3), (k >= 5), 1'b0, 5'd1} ||
                (k >= 3 && uart_do !== 8'h3C)) begin
                n_fail++;
                $display("FAIL write_k%0d: got oe=%b wr=%b rd=%b txc=%0d do=%h expected %b %b 0 1 3c",
                         k, uart_oe, uart_wr, uart_rd, tx_count, uart_do, (k >= 3), (k >= 5));
            end
        end
        tick();
        n_checks++;
        if ({uart_oe, uart_wr, tx_count} !== 7'd0) begin
            n_fail++;
            $display("FAIL write_end: got oe=%b wr=%b txc=%0d expected 0 0 0", uart_oe, uart_wr, tx_count);
        end
    endtask

    task automatic test_contention();
        logic bad;
        apply_reset();
        pad_base = 8'h80;
        for (int unsigned i = 0; i < 3; i++) begin
            tx_valid = 1'b1; tx_data = 8'h11 * 8'(i + 1);
            tick();
        end
        tx_valid = 1'b0;
        uart_rxf = 1'b0; uart_txe = 1'b0;
        for (int unsigned c = 0; c < 600 && rx_count != 5'd16; c++) tick();
        n_checks++;
        if (rx_count !== 5'd16) begin
            n_fail++;
            $display("FAIL contention_fill: got rxc=%0d expected 16", rx_count);
        end
        bad = 1'b0;
        for (int unsigned c = 0; c < 30; c++) begin
            tick();
            if (uart_rd) bad = 1'b1;
        end
        n_checks++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL full_no_read: got rd asserted=%b expected 0", bad);
        end
        bad = (seq.size() != 19);
        for (int unsigned i = 0; i < seq.size() && i < 19; i++)
            if (seq[i] !== ((i < 6) ? i[0] : 1'b0)) bad = 1'b1;
        n_checks++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL contention_order: got %0d transfers (bad order=%b) expected 19 RD,WR x3 then RD", seq.size(), bad);
        end
        n_checks++;
        if (wbytes.size() != 3 || wbytes[0] !== 8'h11 || wbytes[1] !== 8'h22 || wbytes[2] !== 8'h33) begin
            n_fail++;
            $display("FAIL contention_wbytes: got %0d bytes expected 11 22 33", wbytes.size());
        end
        n_checks++;
        if (rx_data !== 8'h80) begin
            n_fail++;
            $display("FAIL contention_head: got %h expected 80", rx_data);
        end
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        bad = 1'b1;
        for (int unsigned c = 0; c < 20 && bad; c++) begin
            tick();
            if (uart_rd) bad = 1'b0;
        end
        uart_rxf = 1'b1; uart_txe = 1'b1;
        n_checks++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL read_after_pop: got no read within 20 cycles expected a read");
        end
        repeat (20) tick();
        for (int unsigned i = 0; i < 16; i++) begin
            n_checks++;
            if (rx_data !== 8'h81 + 8'(i) || rx_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL drain_%0d: got %h v=%b expected %h v=1", i, rx_data, rx_valid, 8'h81 + 8'(i));
            end
            rx_ready = 1'b1;
            tick();
            rx_ready = 1'b0;
        end
    endtask

    task automatic test_tx_full();
        int unsigned accepted;
        logic bad;
        apply_reset();
        accepted = 0;
        for (int unsigned i = 0; i < 20; i++) begin
            tx_valid = 1'b1; tx_data = 8'h50 + 8'(i);
            if (tx_ready) accepted++;
            tick();
        end
        n_checks++;
        if (accepted != 16 || tx_count !== 5'd16 || tx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL tx_fill: got acc=%0d txc=%0d txr=%b expected 16 16 0", accepted, tx_count, tx_ready);
        end
        tx_data = 8'hEE;
        uart_txe = 1'b0;
        bad = 1'b0;
        for (int unsigned c = 0; c < 40 && !tx_ready; c++) begin
            if (tx_count !== 5'd16) bad = 1'b1;
            tick();
        end
        tx_valid = 1'b0;
        n_checks++;
        if (bad !== 1'b0 || tx_count !== 5'd15) begin
            n_fail++;
            $display("FAIL tx_full_pop: got held16=%b txc=%0d expected held16 then 15", !bad, tx_count);
        end
        for (int unsigned c = 0; c < 400 && tx_count != 0; c++) tick();
        repeat (8) tick();
        uart_txe = 1'b1;
        bad = (wbytes.size() != 16);
        for (int unsigned i = 0; i < wbytes.size() && i < 16; i++)
            if (wbytes[i] !== 8'h50 + 8'(i)) bad = 1'b1;
        n_checks++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL tx_full_order: got %0d bytes bad=%b expected 50..5f", wbytes.size(), bad);
        end
    endtask

    task automatic test_back_to_back();
        int unsigned tx_sent, rx_got;
        logic acc_tx, bad_rx, bad_tx;
        apply_reset();
        pad_base = 8'h00;
        tx_sent = 0; rx_got = 0; bad_rx = 1'b0;
        uart_rxf = 1'b0; uart_txe = 1'b0; rx_ready = 1'b1;
        for (int unsigned c = 0; c < 3000 && (wbytes.size() < 40 || rx_got < 40); c++) begin
            tx_valid = (tx_sent < 40);
            tx_data  = 8'(tx_sent) ^ 8'h5A;
            acc_tx   = tx_valid && tx_ready;
            if (rx_valid) begin
                if (rx_data !== 8'(rx_got)) bad_rx = 1'b1;
                rx_got++;
            end
            tick();
            if (acc_tx) tx_sent++;
        end
        tx_valid = 1'b0; uart_rxf = 1'b1; uart_txe = 1'b1;
        bad_tx = (wbytes.size() < 40);
        for (int unsigned i = 0; i < wbytes.size() && i < 40; i++)
            if (wbytes[i] !== (8'(i) ^ 8'h5A)) bad_tx = 1'b1;
        n_checks++;
        if (bad_tx !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_tx: got %0d bytes bad=%b expected 40 in order", wbytes.size(), bad_tx);
        end
        n_checks++;
        if (bad_rx !== 1'b0 || rx_got < 40) begin
            n_fail++;
            $display("FAIL wrap_rx: got %0d bytes bad=%b expected >=40 in order", rx_got, bad_rx);
        end
        repeat (20) tick();
        rx_ready = 1'b0;
    endtask

    task automatic test_reset_mid_wr();
        logic seen;
        apply_reset();
        tx_valid = 1'b1; tx_data = 8'h77;
        tick();
        tx_valid = 1'b0;
        uart_txe = 1'b0;
        seen = 1'b0;
        for (int unsigned c = 0; c < 20 && !seen; c++) begin
            tick();
            if (uart_wr) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_wr_reach: got no write strobe within 20 cycles expected one");
        end
        tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if ({uart_wr, uart_oe, uart_rd, tx_count, rx_count} !== 13'd0) begin
            n_fail++;
            $display("FAIL mid_wr_reset: got wr=%b oe=%b rd=%b txc=%0d rxc=%0d expected all 0",
                     uart_wr, uart_oe, uart_rd, tx_count, rx_count);
        end
        rst = 1'b1; uart_rxf = 1'b0; uart_txe = 1'b0;
        tx_valid = 1'b1; tx_data = 8'h99;
        seq.delete();
        tick();
        tx_valid = 1'b0;
        for (int unsigned c = 0; c < 20 && seq.size() == 0; c++) tick();
        n_checks++;
        if (seq.size() == 0 || seq[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_rr: got %0d transfers first=%b expected first=0 (RD)",
                     seq.size(), (seq.size() != 0) ? seq[0] : 1'bx);
        end
        uart_rxf = 1'b1; uart_txe = 1'b1;
        repeat (20) tick();
    endtask

    initial begin
        rd_prev = 1'b0; oe_prev = 1'b0; pad_base = 8'h00; rd_starts = 0;
        test_reset();
        test_single_read();
        test_single_write();
        test_contention();
        test_tx_full();
        test_back_to_back();
        test_reset_mid_wr();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
